// File: rtl/elevator_pkg.sv
// Shared encodings for the SCAN elevator controller: FSM states, engine codes, travel direction.
package elevator_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_DOOR_OPEN, ST_LOCKED} state_t;

  localparam logic [1:0] ENG_STOP = 2'b00;
  localparam logic [1:0] ENG_UP   = 2'b01;
  localparam logic [1:0] ENG_DOWN = 2'b10;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
endpackage

// File: rtl/elevator_call_scanner.sv
// Combinational call scan: are there calls above/below the evaluated floor, and should the car stop there.
module elevator_call_scanner
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 3
) (
  input  logic [NUM_FLOORS-1:0] cab_i,
  input  logic [NUM_FLOORS-1:0] up_i,
  input  logic [NUM_FLOORS-1:0] dn_i,
  input  logic [FLOOR_W-1:0]    floor_i,
  input  logic                  dir_i,
  output logic                  calls_above_o,
  output logic                  calls_below_o,
  output logic                  stop_here_o
);
  logic [NUM_FLOORS-1:0] calls;
  logic                  ahead;

  always_comb begin
    calls         = cab_i | up_i | dn_i;
    calls_above_o = 1'b0;
    calls_below_o = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(floor_i)) calls_above_o = calls_above_o | calls[i];
      if (i < int'(floor_i)) calls_below_o = calls_below_o | calls[i];
    end
    ahead = (dir_i == DIR_UP) ? calls_above_o : calls_below_o;
    // An opposite-direction hall call is only taken when nothing lies further ahead.
    stop_here_o = cab_i[floor_i]
                | ((dir_i == DIR_UP) ? up_i[floor_i] : dn_i[floor_i])
                | ((up_i[floor_i] | dn_i[floor_i]) & ~ahead);
  end
endmodule

// File: rtl/elevator_scan_controller.sv
// N-floor elevator car controller: call latching, SCAN scheduling, travel/door timing, service lock.
module elevator_scan_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3,
  parameter int CNT_W         = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_FLOORS-1:0] interior_req_i,
  input  logic [NUM_FLOORS-1:0] ext_up_req_i,
  input  logic [NUM_FLOORS-1:0] ext_dn_req_i,
  input  logic                  service_lock_i,
  output logic [1:0]            engine_o,
  output logic [NUM_FLOORS-1:0] doors_o,
  output logic [FLOOR_W-1:0]    current_floor_o,
  output logic [NUM_FLOORS-1:0] pending_o
);
  localparam logic [NUM_FLOORS-1:0] ONE     = NUM_FLOORS'(1);
  localparam logic [NUM_FLOORS-1:0] UP_MASK = ~(ONE << (NUM_FLOORS - 1));
  localparam logic [NUM_FLOORS-1:0] DN_MASK = ~ONE;
  localparam logic [FLOOR_W-1:0]    TOP     = FLOOR_W'(NUM_FLOORS - 1);

  state_t                state_q;
  logic [FLOOR_W-1:0]    floor_q;
  logic                  dir_q;
  logic [CNT_W-1:0]      timer_q;
  logic [1:0]            engine_q;
  logic [NUM_FLOORS-1:0] doors_q, cab_q, up_q, dn_q;
  logic [NUM_FLOORS-1:0] cab_d, up_d, dn_d;

  logic                  arrive, at_end, ahead, enter_door, hold, dir_nx;
  logic                  above, below, stop_here;
  logic [FLOOR_W-1:0]    next_floor, eval_floor;
  logic [NUM_FLOORS-1:0] pend, here, keep, clr_cab, clr_up, clr_dn, req_up, req_dn;

  // On the arrival edge the scan looks at the floor being reached, not the one being left.
  always_comb begin
    arrive     = (state_q == ST_MOVE) && (timer_q == CNT_W'(1));
    next_floor = (dir_q == DIR_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    eval_floor = arrive ? next_floor : floor_q;
  end

  elevator_call_scanner #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_scan (
    .cab_i(cab_q), .up_i(up_q), .dn_i(dn_q), .floor_i(eval_floor), .dir_i(dir_q),
    .calls_above_o(above), .calls_below_o(below), .stop_here_o(stop_here)
  );

  always_comb begin
    pend   = cab_q | up_q | dn_q;
    here   = ONE << eval_floor;
    req_up = ext_up_req_i & UP_MASK;
    req_dn = ext_dn_req_i & DN_MASK;
    at_end = (dir_q == DIR_UP) ? (eval_floor == TOP) : (eval_floor == '0);
    ahead  = (dir_q == DIR_UP) ? above : below;
    dir_nx = ahead ? dir_q : ~dir_q;
    hold   = (state_q == ST_DOOR_OPEN) && |((interior_req_i | req_up | req_dn) & here);
    enter_door = !service_lock_i &&
                 (((state_q == ST_IDLE) && pend[floor_q]) ||
                  (arrive && (stop_here || at_end)) ||
                  (state_q == ST_LOCKED));
    // Calls at the open door's floor refresh the dwell instead of being latched.
    keep    = (state_q == ST_DOOR_OPEN) ? ~here : '1;
    clr_cab = enter_door ? here : '0;
    clr_up  = (enter_door && (!ahead || dir_q == DIR_UP)) ? here : '0;
    clr_dn  = (enter_door && (!ahead || dir_q == DIR_DN)) ? here : '0;
    cab_d   = (cab_q | (interior_req_i & keep)) & ~clr_cab;
    up_d    = (up_q  | (req_up & keep)) & ~clr_up;
    dn_d    = (dn_q  | (req_dn & keep)) & ~clr_dn;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      floor_q  <= '0;
      dir_q    <= DIR_UP;
      timer_q  <= '0;
      engine_q <= ENG_STOP;
      doors_q  <= '0;
      cab_q    <= '0;
      up_q     <= '0;
      dn_q     <= '0;
    end else begin
      cab_q <= cab_d;
      up_q  <= up_d;
      dn_q  <= dn_d;
      if (timer_q != '0) timer_q <= timer_q - CNT_W'(1);
      case (state_q)
        ST_IDLE: begin
          if (service_lock_i) begin
            state_q <= ST_LOCKED;
            doors_q <= here;
          end else if (enter_door) begin
            state_q <= ST_DOOR_OPEN;
            doors_q <= here;
            timer_q <= CNT_W'(DOOR_CYCLES);
            dir_q   <= dir_nx;
          end else if (above || below) begin
            state_q  <= ST_MOVE;
            timer_q  <= CNT_W'(TRAVEL_CYCLES);
            if (above && (dir_q == DIR_UP || !below)) begin
              dir_q    <= DIR_UP;
              engine_q <= ENG_UP;
            end else begin
              dir_q    <= DIR_DN;
              engine_q <= ENG_DOWN;
            end
          end
        end
        ST_MOVE: begin
          if (arrive) begin
            floor_q <= next_floor;
            if (service_lock_i) begin
              state_q  <= ST_LOCKED;
              engine_q <= ENG_STOP;
              doors_q  <= here;
            end else if (enter_door) begin
              state_q  <= ST_DOOR_OPEN;
              engine_q <= ENG_STOP;
              doors_q  <= here;
              timer_q  <= CNT_W'(DOOR_CYCLES);
              dir_q    <= dir_nx;
            end else begin
              timer_q <= CNT_W'(TRAVEL_CYCLES);
            end
          end
        end
        ST_DOOR_OPEN: begin
          if (service_lock_i) begin
            state_q <= ST_LOCKED;
          end else if (hold) begin
            timer_q <= CNT_W'(DOOR_CYCLES);
          end else if (timer_q <= CNT_W'(1)) begin
            state_q <= ST_IDLE;
            doors_q <= '0;
          end
        end
        default: begin
          if (enter_door) begin
            state_q <= ST_DOOR_OPEN;
            timer_q <= CNT_W'(DOOR_CYCLES);
            dir_q   <= dir_nx;
          end
        end
      endcase
    end
  end

  assign engine_o        = engine_q;
  assign doors_o         = doors_q;
  assign current_floor_o = floor_q;
  assign pending_o       = pend;
endmodule

// File: tb/tb_elevator_scan_controller.sv
// Directed bench for the SCAN elevator controller (8 floors, 4-cycle travel, 3-cycle dwell).
module tb_elevator_scan_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] interior_req = '0, ext_up_req = '0, ext_dn_req = '0;
  logic       service_lock = 1'b0;
  logic [1:0] engine;
  logic [7:0] doors, pending;
  logic [2:0] current_floor;
  int total = 0, bad = 0;

  elevator_scan_controller #(.NUM_FLOORS(8), .FLOOR_W(3), .TRAVEL_CYCLES(4),
                             .DOOR_CYCLES(3), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .interior_req_i(interior_req), .ext_up_req_i(ext_up_req),
    .ext_dn_req_i(ext_dn_req), .service_lock_i(service_lock), .engine_o(engine),
    .doors_o(doors), .current_floor_o(current_floor), .pending_o(pending)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    rst = 1'b1; interior_req = '0; ext_up_req = '0; ext_dn_req = '0; service_lock = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_floor(input int f, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (int'(current_floor) == f) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_doors(input bit open, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((doors != 8'h00) == open) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #1;
    total++; if (engine !== 2'b00) begin bad++; $display("FAIL rst_engine got=%b exp=00", engine); end
    total++; if (doors !== 8'h00) begin bad++; $display("FAIL rst_doors got=%h exp=00", doors); end
    total++; if (current_floor !== 3'd0) begin bad++; $display("FAIL rst_floor got=%0d exp=0", current_floor); end
    total++; if (pending !== 8'h00) begin bad++; $display("FAIL rst_pending got=%h exp=00", pending); end
    do_reset();
    repeat (3) @(negedge clk);
    total++; if (engine !== 2'b00 || doors !== 8'h00) begin bad++; $display("FAIL idle_quiet got eng=%b doors=%h exp 00/00", engine, doors); end
  endtask

  task automatic test_single_call;
    int n;
    do_reset();
    interior_req = 8'h20; @(negedge clk); interior_req = '0;
    total++; if (pending !== 8'h20) begin bad++; $display("FAIL single_latch got=%h exp=20", pending); end
    @(negedge clk);
    n = 0;
    while (engine == 2'b01 && n < 40) begin n++; @(negedge clk); end
    total++; if (n != 20) begin bad++; $display("FAIL single_travel got=%0d exp=20", n); end
    total++; if (current_floor !== 3'd5) begin bad++; $display("FAIL single_floor got=%0d exp=5", current_floor); end
    total++; if (doors !== 8'h20) begin bad++; $display("FAIL single_doors got=%h exp=20", doors); end
    total++; if (pending[5] !== 1'b0) begin bad++; $display("FAIL single_clear got=%b exp=0", pending[5]); end
    n = 0;
    while (doors == 8'h20 && n < 10) begin n++; @(negedge clk); end
    total++; if (n != 3) begin bad++; $display("FAIL single_dwell got=%0d exp=3", n); end
    repeat (2) @(negedge clk);
    total++; if (engine !== 2'b00 || doors !== 8'h00) begin bad++; $display("FAIL single_idle got eng=%b doors=%h exp 00/00", engine, doors); end
  endtask

  task automatic test_scan;
    bit ok;
    do_reset();
    interior_req = 8'h40; @(negedge clk); interior_req = '0;
    wait_floor(3, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL scan_reach3 got=%0d exp=3", current_floor); end
    ext_dn_req = 8'h02; interior_req = 8'h40; @(negedge clk); ext_dn_req = '0; interior_req = '0;
    wait_doors(1'b1, 100, ok);
    total++; if (!ok || doors !== 8'h40 || current_floor !== 3'd6) begin bad++; $display("FAIL scan_first got doors=%h fl=%0d exp 40/6", doors, current_floor); end
    wait_doors(1'b0, 20, ok);
    wait_doors(1'b1, 100, ok);
    total++; if (!ok || doors !== 8'h02 || current_floor !== 3'd1) begin bad++; $display("FAIL scan_second got doors=%h fl=%0d exp 02/1", doors, current_floor); end
    total++; if (pending !== 8'h00) begin bad++; $display("FAIL scan_pending got=%h exp=00", pending); end
  endtask

  task automatic test_hall_dir;
    bit ok;
    do_reset();
    interior_req = 8'h40; ext_dn_req = 8'h08; @(negedge clk); interior_req = '0; ext_dn_req = '0;
    wait_doors(1'b1, 100, ok);
    total++; if (!ok || doors !== 8'h40 || current_floor !== 3'd6) begin bad++; $display("FAIL hall_skip got doors=%h fl=%0d exp 40/6", doors, current_floor); end
    total++; if (pending !== 8'h08) begin bad++; $display("FAIL hall_kept got=%h exp=08", pending); end
    wait_doors(1'b0, 20, ok);
    wait_doors(1'b1, 100, ok);
    total++; if (!ok || doors !== 8'h08 || current_floor !== 3'd3) begin bad++; $display("FAIL hall_down got doors=%h fl=%0d exp 08/3", doors, current_floor); end
    total++; if (pending !== 8'h00) begin bad++; $display("FAIL hall_pending got=%h exp=00", pending); end
  endtask

  task automatic test_door_hold;
    bit ok;
    int n;
    do_reset();
    interior_req = 8'h10; @(negedge clk); interior_req = '0;
    wait_doors(1'b1, 100, ok);
    total++; if (!ok || doors !== 8'h10) begin bad++; $display("FAIL hold_open got=%h exp=10", doors); end
    repeat (2) @(negedge clk);
    total++; if (doors !== 8'h10) begin bad++; $display("FAIL hold_last got=%h exp=10", doors); end
    interior_req = 8'h10; @(negedge clk); interior_req = '0;
    total++; if (pending[4] !== 1'b0) begin bad++; $display("FAIL hold_nolatch got=%b exp=0", pending[4]); end
    n = 0;
    while (doors == 8'h10 && n < 10) begin n++; @(negedge clk); end
    total++; if (n != 3) begin bad++; $display("FAIL hold_extend got=%0d exp=3", n); end
  endtask

  task automatic test_lock;
    bit ok;
    int n;
    do_reset();
    interior_req = 8'h10; @(negedge clk); interior_req = '0;
    wait_floor(1, 40, ok);
    service_lock = 1'b1;
    wait_doors(1'b1, 40, ok);
    total++; if (!ok || doors !== 8'h04 || current_floor !== 3'd2) begin bad++; $display("FAIL lock_stop got doors=%h fl=%0d exp 04/2", doors, current_floor); end
    interior_req = 8'h80; @(negedge clk); interior_req = '0;
    repeat (10) @(negedge clk);
    total++; if (doors !== 8'h04 || engine !== 2'b00) begin bad++; $display("FAIL lock_hold got doors=%h eng=%b exp 04/00", doors, engine); end
    total++; if (pending !== 8'h90) begin bad++; $display("FAIL lock_latch got=%h exp=90", pending); end
    service_lock = 1'b0;
    @(negedge clk);
    n = 0;
    while (doors == 8'h04 && n < 10) begin n++; @(negedge clk); end
    total++; if (n != 3) begin bad++; $display("FAIL lock_release got=%0d exp=3", n); end
    repeat (2) @(negedge clk);
    total++; if (engine !== 2'b01) begin bad++; $display("FAIL lock_up got=%b exp=01", engine); end
    wait_doors(1'b1, 60, ok);
    total++; if (!ok || doors !== 8'h10) begin bad++; $display("FAIL lock_stop4 got=%h exp=10", doors); end
    wait_doors(1'b0, 20, ok);
    wait_doors(1'b1, 60, ok);
    total++; if (!ok || doors !== 8'h80 || current_floor !== 3'd7) begin bad++; $display("FAIL lock_stop7 got doors=%h fl=%0d exp 80/7", doors, current_floor); end
  endtask

  task automatic test_reset_mid_move;
    bit ok;
    do_reset();
    interior_req = 8'h20; @(negedge clk); interior_req = '0;
    wait_floor(2, 40, ok);
    total++; if (!ok || engine !== 2'b01) begin bad++; $display("FAIL mid_moving got fl=%0d eng=%b exp 2/01", current_floor, engine); end
    #1 rst = 1'b1;
    #1;
    total++; if (engine !== 2'b00 || doors !== 8'h00) begin bad++; $display("FAIL mid_outs got eng=%b doors=%h exp 00/00", engine, doors); end
    total++; if (current_floor !== 3'd0 || pending !== 8'h00) begin bad++; $display("FAIL mid_state got fl=%0d pend=%h exp 0/00", current_floor, pending); end
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (engine !== 2'b00 || current_floor !== 3'd0) begin bad++; $display("FAIL mid_after got eng=%b fl=%0d exp 00/0", engine, current_floor); end
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_scan();
    test_hall_dir();
    test_door_hold();
    test_lock();
    test_reset_mid_move();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
